// File: rtl/ecg_sample_scheduler.sv
// Paces buffered ADC samples into the Pan-Tompkins detector at one sample per slot and qualifies its beats.
// Optional macro ECG_BEAT_COUNT_EN adds a saturating 16-bit beat_count output.
module ecg_sample_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int SAMPLE_DIV     = 250,
  parameter int WARMUP_SAMPLES = 400
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          pt_en,
  output logic [DATA_WIDTH-1:0]         pt_xin,
  input  logic                          pt_y,
  output logic                          beat,
  output logic                          running,
  output logic                          warm,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ECG_BEAT_COUNT_EN
  ,
  output logic [15:0]                   beat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(WARMUP_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic [SW-1:0]         slot_cnt;
  logic [WW-1:0]         warm_cnt;
  logic                  pt_en_q, y_q;
  logic                  go, full, empty, push, pop, slot_end, last_warm;

  // A start is only honoured from IDLE and always loses to a simultaneous stop.
  assign go        = start && !stop && (state == IDLE);
  assign running   = (state != IDLE);
  assign warm      = (state == RUN);
  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign s_ready   = running && !full;
  assign push      = s_valid && s_ready && !stop;
  assign slot_end  = running && (slot_cnt == SW'(SAMPLE_DIV - 1));
  assign pop       = slot_end && !empty && !stop;
  assign last_warm = (state == WARMUP) && pt_en && (warm_cnt == WW'(WARMUP_SAMPLES - 1));
  assign fifo_level = level;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = WARMUP;
      WARMUP:  if (stop) state_nxt = IDLE;
               else if (last_warm) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: storage has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   slot_cnt <= '0;
    else if (!running || stop)   slot_cnt <= '0;
    else if (slot_end)           slot_cnt <= '0;
    else                         slot_cnt <= slot_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           warm_cnt <= '0;
    else if (go || stop)                 warm_cnt <= '0;
    else if ((state == WARMUP) && pt_en) warm_cnt <= warm_cnt + WW'(1);
  end

  // Strobe and data for the detector; pt_xin holds between strobes and across stop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pt_en   <= 1'b0;
      pt_xin  <= '0;
      pt_en_q <= 1'b0;
    end else begin
      pt_en   <= pop;
      pt_en_q <= pt_en && !stop;
      if (pop) pt_xin <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (go || stop)   y_q <= 1'b0;
      else if (pt_en_q) y_q <= pt_y;
      if (go)                             underrun <= 1'b0;
      else if (slot_end && empty && !stop) underrun <= 1'b1;
    end
  end

  // Detector output is valid the cycle after its strobe; report only its rising edges once warm.
  assign beat = warm && pt_en_q && pt_y && !y_q;

`ifdef ECG_BEAT_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             beat_count <= '0;
    else if (go)                           beat_count <= '0;
    else if (beat && beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
  end
`endif

endmodule
